// File: rtl/audio_mix_pkg.sv
// Shared types and constants for the audio mix sequencer.
package audio_mix_pkg;

  localparam int unsigned SampleDivDefault = 250;
  localparam int unsigned SampleDivMin     = 12;
  localparam int unsigned SampleDivMax     = 4095;
  localparam int unsigned DivW             = 12;
  // Four full-scale 16-bit terms need two guard bits.
  localparam int unsigned AccW             = 18;

  // Source positions: bit index into src_en and the order of the add sequence.
  localparam logic [1:0] SrcAudio1 = 2'd0;
  localparam logic [1:0] SrcAudio2 = 2'd1;
  localparam logic [1:0] SrcSpeech = 2'd2;
  localparam logic [1:0] SrcYm     = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StAddL,
    StAddR,
    StSat,
    StOut
  } state_e;

  // Offset-binary 8-bit DAC code to signed 16-bit full scale.
  function automatic logic [15:0] dac_to_signed(input logic [7:0] code);
    return {code, 8'h00} ^ 16'h8000;
  endfunction

endpackage

// File: rtl/audio_mix_sat.sv
// Attenuate (arithmetic shift) and clamp both channel sums to 16-bit signed.
module audio_mix_sat
  import audio_mix_pkg::*;
(
  input  logic [AccW-1:0] sum_l_i,
  input  logic [AccW-1:0] sum_r_i,
  input  logic [1:0]      att_i,
  input  logic            mute_i,
  output logic [15:0]     sat_l_o,
  output logic [15:0]     sat_r_o
);

  function automatic logic [15:0] shift_clamp(input logic [AccW-1:0] sum,
                                              input logic [1:0]      att,
                                              input logic            mute);
    logic signed [AccW-1:0] shifted;
    shifted = $signed(sum) >>> att;
    if (mute) return 16'h0000;
    if (shifted > 18'sd32767) return 16'h7FFF;
    if (shifted < -18'sd32768) return 16'h8000;
    return shifted[15:0];
  endfunction

  // Same shift/clamp datapath applied to both channels.
  always_comb begin
    sat_l_o = shift_clamp(sum_l_i, att_i, mute_i);
    sat_r_o = shift_clamp(sum_r_i, att_i, mute_i);
  end

endmodule

// File: rtl/audio_mix_sequencer.sv
// Four-source stereo mixer: one shared adder walks the sources serially per sample.
module audio_mix_sequencer
  import audio_mix_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = SampleDivDefault
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [7:0]  audio_1,
  input  logic [7:0]  audio_2,
  input  logic [15:0] speech,
  input  logic [15:0] ym_left,
  input  logic [15:0] ym_right,
  input  logic [3:0]  src_en,
  input  logic [1:0]  att,
  input  logic        mute,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_valid
);

  localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);

  logic [DivW-1:0] div_q;
  logic            tick;
  state_e          state_q;
  logic [1:0]      step_q;
  logic [7:0]      a1_q, a2_q;
  logic [15:0]     sp_q, yl_q, yr_q;
  logic [3:0]      en_q;
  logic [1:0]      att_q;
  logic            mute_q;
  logic [AccW-1:0] acc_q, hold_l_q, sum;
  logic [15:0]     term, sat_l, sat_r, out_l_q, out_r_q;
  logic            out_valid_q;

  assign tick = (div_q == DivLast);

  // Free-running sample-rate divider.
  always_ff @(posedge clk_sys) begin
    if (reset || tick) div_q <= '0;
    else               div_q <= div_q + 1'b1;
  end

  // Select the term for the current add step; disabled sources add zero.
  always_comb begin
    term = 16'h0000;
    unique case (step_q)
      SrcAudio1: if (en_q[SrcAudio1]) term = dac_to_signed(a1_q);
      SrcAudio2: if (en_q[SrcAudio2]) term = dac_to_signed(a2_q);
      SrcSpeech: if (en_q[SrcSpeech]) term = sp_q ^ 16'h8000;
      SrcYm:     if (en_q[SrcYm])     term = (state_q == StAddR) ? yr_q : yl_q;
    endcase
    sum = acc_q + {{(AccW-16){term[15]}}, term};
  end

  audio_mix_sat u_sat (
    .sum_l_i (hold_l_q),
    .sum_r_i (acc_q),
    .att_i   (att_q),
    .mute_i  (mute_q),
    .sat_l_o (sat_l),
    .sat_r_o (sat_r)
  );

  // Sample sequencer: latch, accumulate left then right, saturate, publish.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= StIdle;
      step_q      <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      sp_q        <= '0;
      yl_q        <= '0;
      yr_q        <= '0;
      en_q        <= '0;
      att_q       <= '0;
      mute_q      <= 1'b0;
      acc_q       <= '0;
      hold_l_q    <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: if (tick) state_q <= StLatch;
        StLatch: begin
          a1_q    <= audio_1;
          a2_q    <= audio_2;
          sp_q    <= speech;
          yl_q    <= ym_left;
          yr_q    <= ym_right;
          en_q    <= src_en;
          att_q   <= att;
          mute_q  <= mute;
          acc_q   <= '0;
          step_q  <= '0;
          state_q <= StAddL;
        end
        StAddL: begin
          step_q <= step_q + 2'd1;
          if (step_q == SrcYm) begin
            // Park the left sum so the adder can start on the right channel.
            hold_l_q <= sum;
            acc_q    <= '0;
            state_q  <= StAddR;
          end else begin
            acc_q <= sum;
          end
        end
        StAddR: begin
          step_q <= step_q + 2'd1;
          acc_q  <= sum;
          if (step_q == SrcYm) state_q <= StSat;
        end
        StSat: begin
          out_l_q     <= sat_l;
          out_r_q     <= sat_r;
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = out_valid_q;

  // A divider outside its legal range would let ticks overrun the sequence.
  a_div_range: assert property (@(posedge clk_sys)
    (SAMPLE_DIV >= SampleDivMin) && (SAMPLE_DIV <= SampleDivMax));
  a_tick_idle: assert property (@(posedge clk_sys) disable iff (reset)
    tick |-> (state_q == StIdle));

endmodule
